// File: rtl/pipe_hazard_ctl.sv
// Hazard and sequencing controller for a 5-stage MIPS pipeline: post-reset hold,
// load-use stalls, branch flushes, debug halt/drain handshake and event counters.
module pipe_hazard_ctl #(
    parameter int INIT_CYCLES  = 4,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_id_valid,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_rt,
    input  logic             ex_mem_pcsrc,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_bubble,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             halt_ack,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    // One shared down-counter serves both the INIT hold and the DRAIN countdown.
    localparam int MAX_C = (INIT_CYCLES > DRAIN_CYCLES) ? INIT_CYCLES : DRAIN_CYCLES;
    localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;
    localparam logic [CW-1:0] INIT_LOAD  = CW'(INIT_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

    state_t        st;
    logic [CW-1:0] cnt;
    logic          lu;
    logic          br;

    assign state = st;

    assign lu = if_id_valid & id_ex_memread & (id_ex_rt != 5'd0) &
                ((id_ex_rt == if_id_rs) | (if_id_uses_rt & (id_ex_rt == if_id_rt)));
    assign br = ex_mem_pcsrc & ((st == S_RUN) | (st == S_DRAIN));

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_bubble    = 1'b1;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        if (br) begin
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_bubble    = 1'b0;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end else if (st == S_RUN && !lu) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            id_bubble   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= S_INIT;
            cnt       <= INIT_LOAD;
            stall_cnt <= '0;
            flush_cnt <= '0;
            halt_ack  <= 1'b0;
        end else begin
            if (st == S_RUN && lu && !br && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (br && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
            halt_ack <= 1'b0;
            case (st)
                S_INIT: begin
                    if (cnt == '0) st <= S_RUN;
                    else           cnt <= cnt - 1'b1;
                end
                S_RUN: begin
                    // A redirect wins over a halt request; the request is re-seen next cycle.
                    if (halt_req && !br) begin
                        st  <= S_DRAIN;
                        cnt <= DRAIN_LOAD;
                    end
                end
                S_DRAIN: begin
                    if (!halt_req) begin
                        st <= S_RUN;
                    end else if (br) begin
                        cnt <= DRAIN_LOAD;
                    end else if (cnt == '0) begin
                        st       <= S_HALTED;
                        halt_ack <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HALTED: begin
                    if (!halt_req) st <= S_RUN;
                    else           halt_ack <= 1'b1;
                end
                default: st <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Scoreboard bench for pipe_hazard_ctl: a driver pushes model predictions per cycle,
// a monitor pops and compares them against two DUTs (16-bit and 2-bit counters).
module tb_pipe_hazard_ctl;

    localparam int INIT_CYCLES  = 4;
    localparam int DRAIN_CYCLES = 3;

    logic       clk;
    logic       rst;
    logic       if_id_valid;
    logic [4:0] if_id_rs;
    logic [4:0] if_id_rt;
    logic       if_id_uses_rt;
    logic       id_ex_memread;
    logic [4:0] id_ex_rt;
    logic       ex_mem_pcsrc;
    logic       halt_req;

    logic        pc_write, if_id_write, id_bubble;
    logic        flush_if_id, flush_id_ex, flush_ex_mem, halt_ack;
    logic [15:0] stall_cnt, flush_cnt;
    logic [1:0]  state;

    logic        s_pc_write, s_if_id_write, s_id_bubble;
    logic        s_flush_if_id, s_flush_id_ex, s_flush_ex_mem, s_halt_ack;
    logic [1:0]  s_stall_cnt, s_flush_cnt;
    logic [1:0]  s_state;

    pipe_hazard_ctl #(.INIT_CYCLES(INIT_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_rs(if_id_rs),
        .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt), .id_ex_memread(id_ex_memread),
        .id_ex_rt(id_ex_rt), .ex_mem_pcsrc(ex_mem_pcsrc), .halt_req(halt_req),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_bubble(id_bubble),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
        .halt_ack(halt_ack), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
    );

    pipe_hazard_ctl #(.INIT_CYCLES(INIT_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_rs(if_id_rs),
        .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt), .id_ex_memread(id_ex_memread),
        .id_ex_rt(id_ex_rt), .ex_mem_pcsrc(ex_mem_pcsrc), .halt_req(halt_req),
        .pc_write(s_pc_write), .if_id_write(s_if_id_write), .id_bubble(s_id_bubble),
        .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex), .flush_ex_mem(s_flush_ex_mem),
        .halt_ack(s_halt_ack), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .state(s_state)
    );

    typedef struct {
        logic        pc_write, if_id_write, id_bubble;
        logic        flush_if_id, flush_id_ex, flush_ex_mem, halt_ack;
        logic [15:0] stall_cnt, flush_cnt;
        logic [1:0]  state;
        logic [1:0]  s_stall_cnt, s_flush_cnt;
    } want_t;

    want_t want_q[$];
    int    n_cmp = 0;
    int    n_err = 0;

    // Reference model: mode 0..3 = INIT/RUN/DRAIN/HALTED; seen counts cycles spent in
    // the current hold window; event totals are unbounded and clamped on comparison.
    int m_mode    = 0;
    int m_seen    = 0;
    int m_stalls  = 0;
    int m_flushes = 0;
    bit m_ack     = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] need);
        n_cmp++;
        if (got !== need) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, need, $time);
        end
    endtask

    function automatic int clamp(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // Predict this cycle's outputs from the driven inputs, then advance to the next edge.
    task automatic model_step();
        want_t w;
        bit    lu, br, flow;
        lu = if_id_valid && id_ex_memread && (id_ex_rt != 0) &&
             ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
        if (rst) begin
            m_mode = 0; m_seen = 0; m_stalls = 0; m_flushes = 0; m_ack = 1'b0;
        end
        br   = ex_mem_pcsrc && (m_mode == 1 || m_mode == 2);
        flow = br || (m_mode == 1 && !lu);
        w.pc_write     = flow;
        w.if_id_write  = flow;
        w.id_bubble    = !flow;
        w.flush_if_id  = br;
        w.flush_id_ex  = br;
        w.flush_ex_mem = br;
        w.halt_ack     = m_ack;
        w.state        = 2'(m_mode);
        w.stall_cnt    = 16'(clamp(m_stalls, 16));
        w.flush_cnt    = 16'(clamp(m_flushes, 16));
        w.s_stall_cnt  = 2'(clamp(m_stalls, 2));
        w.s_flush_cnt  = 2'(clamp(m_flushes, 2));
        want_q.push_back(w);
        if (rst) return;

        if (m_mode == 1 && lu && !br) m_stalls++;
        if (br) m_flushes++;
        case (m_mode)
            0: begin
                m_seen++;
                if (m_seen == INIT_CYCLES) m_mode = 1;
            end
            1: if (halt_req && !br) begin m_mode = 2; m_seen = 0; end
            2: begin
                if (!halt_req) m_mode = 1;
                else if (br) m_seen = 0;
                else begin
                    m_seen++;
                    if (m_seen == DRAIN_CYCLES) m_mode = 3;
                end
            end
            default: if (!halt_req) m_mode = 1;
        endcase
        m_ack = (m_mode == 3);
    endtask

    task automatic drive(input bit r, input bit v, input logic [4:0] rs, input logic [4:0] rt,
                         input bit urt, input bit mr, input logic [4:0] ert,
                         input bit pc, input bit hr);
        @(posedge clk);
        #1;
        rst = r; if_id_valid = v; if_id_rs = rs; if_id_rt = rt; if_id_uses_rt = urt;
        id_ex_memread = mr; id_ex_rt = ert; ex_mem_pcsrc = pc; halt_req = hr;
        model_step();
    endtask

    task automatic idle(input bit hr);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, hr);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        want_t w;
        forever begin
            @(negedge clk);
            if (want_q.size() > 0) begin
                w = want_q.pop_front();
                check("pc_write",     16'(pc_write),     16'(w.pc_write));
                check("if_id_write",  16'(if_id_write),  16'(w.if_id_write));
                check("id_bubble",    16'(id_bubble),    16'(w.id_bubble));
                check("flush_if_id",  16'(flush_if_id),  16'(w.flush_if_id));
                check("flush_id_ex",  16'(flush_id_ex),  16'(w.flush_id_ex));
                check("flush_ex_mem", 16'(flush_ex_mem), 16'(w.flush_ex_mem));
                check("halt_ack",     16'(halt_ack),     16'(w.halt_ack));
                check("state",        16'(state),        16'(w.state));
                check("stall_cnt",    stall_cnt,         w.stall_cnt);
                check("flush_cnt",    flush_cnt,         w.flush_cnt);
                check("sat_state",     16'(s_state),     16'(w.state));
                check("sat_pc_write",  16'(s_pc_write),  16'(w.pc_write));
                check("sat_halt_ack",  16'(s_halt_ack),  16'(w.halt_ack));
                check("sat_stall_cnt", 16'(s_stall_cnt), 16'(w.s_stall_cnt));
                check("sat_flush_cnt", 16'(s_flush_cnt), 16'(w.s_flush_cnt));
            end
        end
    end

    initial begin
        bit hr;
        logic [4:0] pick [4];
        rst = 1'b1; if_id_valid = 1'b0; if_id_rs = '0; if_id_rt = '0; if_id_uses_rt = 1'b0;
        id_ex_memread = 1'b0; id_ex_rt = '0; ex_mem_pcsrc = 1'b0; halt_req = 1'b0;

        // Reset for two cycles, then the INIT hold and a little RUN time.
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (6) idle(1'b0);

        // Load-use on rs, then the same with id_ex_rt = 0.
        drive(1'b0, 1'b1, 5'd8, 5'd1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0);
        idle(1'b0);
        drive(1'b0, 1'b1, 5'd0, 5'd1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
        // rt-only match: ignored without uses_rt, stalls with it.
        drive(1'b0, 1'b1, 5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
        idle(1'b0);
        // Load-use together with a taken branch: the redirect wins.
        drive(1'b0, 1'b1, 5'd8, 5'd1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0);
        idle(1'b0);

        // Halt held through the full drain, then released.
        repeat (6) idle(1'b1);
        repeat (2) idle(1'b0);
        // Halt with a redirect in the second drain cycle.
        idle(1'b1);
        idle(1'b1);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1);
        repeat (5) idle(1'b1);
        repeat (2) idle(1'b0);

        // Five stalls saturate the 2-bit counter.
        repeat (5) begin
            drive(1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0);
            idle(1'b0);
        end

        // Reset mid-drain.
        repeat (2) idle(1'b1);
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
        repeat (6) idle(1'b0);

        // Randomized traffic with a slowly toggling halt level and rare resets.
        pick[0] = 5'd0; pick[1] = 5'd8; pick[2] = 5'd9; pick[3] = 5'd17;
        hr = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) hr = !hr;
            drive(($urandom_range(0, 399) == 0),
                  1'($urandom_range(0, 3) != 0),
                  pick[$urandom_range(0, 3)],
                  pick[$urandom_range(0, 3)],
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  pick[$urandom_range(0, 3)],
                  ($urandom_range(0, 7) == 0),
                  hr);
        end

        for (int i = 0; i < 10 && want_q.size() != 0; i++) @(negedge clk);
        #1;
        check("queue_drained", 16'(want_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
